exe_mem_skid_stage: RTL and testbench
=====================================

Name: exe_mem_skid_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU.
- Captures the ALU result plus control and destination fields into a two-entry skid buffer, and presents them to the memory stage over a valid/ready handshake.
- Owns the NZCV status register, which is updated when an S-bit instruction is accepted.
- Decouples memory-stage stalls from the execute stage without a combinational ready path.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_ADDR_W, 4, width of destination register index.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  squash all buffered entries (branch taken)
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- alu_result  in  DATA_W  ALU output
- alu_cout  in  1  ALU carry out
- alu_ovf  in  1  ALU signed-overflow flag
- s_bit  in  1  instruction updates status flags
- wb_en_in  in  1  register writeback enable
- mem_r_en_in  in  1  load
- mem_w_en_in  in  1  store
- dest_in  in  REG_ADDR_W  destination register
- store_val_in  in  DATA_W  store data (Rm value)
- out_valid  out  1  entry available to memory stage
- out_ready  in  1  memory stage accepts entry
- alu_result_out  out  DATA_W  registered result
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls
- dest_out  out  REG_ADDR_W  registered destination
- store_val_out  out  DATA_W  registered store data
- status  out  4  {N,Z,C,V}, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; skid valid=0; status=4'b0000.
  - All data and control outputs are 0, and in_ready=1 after reset is released.
- Storage: output register (OR) and skid register (SK), each with a valid bit.
- in_ready = ~SK.valid. It is a pure register output with no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush.
- Drain = out_valid & out_ready.
- Next-state rules, evaluated in priority order:
  - flush: OR.valid<=0 and SK.valid<=0. The input is discarded, even if in_valid is asserted. Flush has priority over every other event.
  - OR empty or Drain, SK.valid=1: SK moves to OR. If Accept, the new input goes to SK; otherwise SK.valid<=0.
  - OR empty or Drain, SK.valid=0: if Accept, the input goes to OR; otherwise OR.valid<=Drain?0:OR.valid.
  - OR full and no Drain: if Accept, the input goes to SK; OR holds.
- Ordering: entries leave in acceptance order. OR always holds the oldest entry.
- Latency: an accepted input appears on the outputs the next cycle when OR is empty or draining; it is never visible in the same cycle.
- Throughput: one entry per cycle when out_ready is held at 1.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Status register, updated on the edge where Accept=1 and s_bit=1:
  - N<=alu_result[DATA_W-1]
  - Z<=(alu_result==0)
  - C<=alu_cout
  - V<=alu_ovf
- Status is otherwise held. Flush never alters status, because flags commit at acceptance in program order.
- Flags are taken unchanged from the ALU for every opcode; this stage does no per-opcode carry masking.
- An entry with wb_en=mem_r_en=mem_w_en=0 (compare/test) still flows through the buffer normally.
- Reset asserted mid-transfer clears everything immediately; no partial entry is retained.

Optional Feature:
- Macro: STATUS_FWD_EN.
- When defined:
  - Adds output status_fwd [3:0].
  - status_fwd equals the value status will take at the next edge: the new flags when Accept&s_bit, else status. It is combinational from the inputs.
  - Lets the decode-stage condition check see flags from the instruction accepted this cycle.
- When undefined: the port and its logic are absent, and consumers use registered status, one cycle later.

Test Plan:
- Reset, then one entry:
  - Stimulus: rst_n low then high; in_valid=1, alu_result=32'h0000_0005, s_bit=1, cout=0, ovf=0, out_ready=1.
  - Response: next cycle out_valid=1, alu_result_out=5, status=4'b0000.
- Zero and carry flags:
  - Stimulus: alu_result=0, cout=1, s_bit=1.
  - Response: status=4'b0110 one cycle after acceptance.
  - Then alu_result=32'h8000_0000, ovf=1, s_bit=0: status stays 4'b0110.
- Backpressure:
  - Stimulus: out_ready=0; push A=1, B=2 on consecutive cycles.
  - Response: in_ready=0 after B; a third push C=3 is held off.
  - Then out_ready=1: outputs are 1, 2, 3 in order, and in_ready returns to 1 the cycle after A drains.
- Flush:
  - Stimulus: OR and SK full; assert flush with in_valid=1, alu_result=7, s_bit=1.
  - Response: next cycle out_valid=0, in_ready=1, status unchanged, and value 7 never appears.
- Full throughput:
  - Stimulus: in_valid=1 and out_ready=1 for 8 cycles, values 0..7.
  - Response: out_valid=1 from cycle 1; values 0..7 consecutive with no bubbles; SK never used.
- STATUS_FWD_EN:
  - Stimulus: macro defined; accept alu_result=0 with s_bit=1.
  - Response: status_fwd=4'b0100 in the same cycle; status=4'b0100 on the next cycle.

Source files
------------

// File: rtl/exe_mem_skid_stage.sv
// Execute-to-memory pipeline stage: a two-entry skid buffer (output + skid register) with NZCV ownership.
// Optional macro STATUS_FWD_EN adds status_fwd, the flag value that status takes at the next edge.
module exe_mem_skid_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_cout,
    input  logic                  alu_ovf,
    input  logic                  s_bit,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [DATA_W-1:0]     store_val_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [DATA_W-1:0]     store_val_out,
`ifdef STATUS_FWD_EN
    output logic [3:0]            status_fwd,
`endif
    output logic [3:0]            status
);

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     store_val;
    } entry_t;

    entry_t     in_entry;
    entry_t     or_q, or_d;
    entry_t     sk_q, sk_d;
    logic       or_valid_q, or_valid_d;
    logic       sk_valid_q, sk_valid_d;
    logic [3:0] status_q, status_d;
    logic [3:0] new_flags;
    logic       accept;
    logic       drain;

    assign in_entry = '{
        result:    alu_result,
        wb_en:     wb_en_in,
        mem_r_en:  mem_r_en_in,
        mem_w_en:  mem_w_en_in,
        dest:      dest_in,
        store_val: store_val_in
    };

    // in_ready depends only on the skid register, so memory-stage stalls never reach execute combinationally.
    assign accept = in_valid & ~sk_valid_q & ~flush;
    assign drain  = or_valid_q & out_ready;

    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (!or_valid_q || drain) begin
            if (sk_valid_q) begin
                or_d       = sk_q;
                or_valid_d = 1'b1;
                if (accept) begin
                    sk_d       = in_entry;
                    sk_valid_d = 1'b1;
                end else begin
                    sk_valid_d = 1'b0;
                end
            end else if (accept) begin
                or_d       = in_entry;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sk_d       = in_entry;
            sk_valid_d = 1'b1;
        end
    end

    // Flags commit at acceptance, so a later flush of the entry leaves them untouched.
    assign new_flags = {alu_result[DATA_W-1], (alu_result == '0), alu_cout, alu_ovf};

    always_comb begin
        status_d = status_q;
        if (accept && s_bit) begin
            status_d = new_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            status_q   <= 4'b0000;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            status_q   <= status_d;
        end
    end

    assign in_ready       = ~sk_valid_q;
    assign out_valid      = or_valid_q;
    assign alu_result_out = or_q.result;
    assign wb_en_out      = or_q.wb_en;
    assign mem_r_en_out   = or_q.mem_r_en;
    assign mem_w_en_out   = or_q.mem_w_en;
    assign dest_out       = or_q.dest;
    assign store_val_out  = or_q.store_val;
    assign status         = status_q;

`ifdef STATUS_FWD_EN
    assign status_fwd = status_d;
`endif

endmodule

// File: tb/tb_exe_mem_skid_stage.sv
// Bench for exe_mem_skid_stage: a FIFO/flag model checked every cycle plus directed literal checks.
module tb_exe_mem_skid_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int ENT_W      = 2 * DATA_W + 3 + REG_ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_cout;
    logic                  alu_ovf;
    logic                  s_bit;
    logic                  wb_en_in;
    logic                  mem_r_en_in;
    logic                  mem_w_en_in;
    logic [REG_ADDR_W-1:0] dest_in;
    logic [DATA_W-1:0]     store_val_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     alu_result_out;
    logic                  wb_en_out;
    logic                  mem_r_en_out;
    logic                  mem_w_en_out;
    logic [REG_ADDR_W-1:0] dest_out;
    logic [DATA_W-1:0]     store_val_out;
    logic [3:0]            status;
`ifdef STATUS_FWD_EN
    logic [3:0]            status_fwd;
`endif

    int tests = 0;
    int fails = 0;

    exe_mem_skid_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_cout       (alu_cout),
        .alu_ovf        (alu_ovf),
        .s_bit          (s_bit),
        .wb_en_in       (wb_en_in),
        .mem_r_en_in    (mem_r_en_in),
        .mem_w_en_in    (mem_w_en_in),
        .dest_in        (dest_in),
        .store_val_in   (store_val_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_result_out (alu_result_out),
        .wb_en_out      (wb_en_out),
        .mem_r_en_out   (mem_r_en_out),
        .mem_w_en_out   (mem_w_en_out),
        .dest_out       (dest_out),
        .store_val_out  (store_val_out),
`ifdef STATUS_FWD_EN
        .status_fwd     (status_fwd),
`endif
        .status         (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered queue of at most two accepted entries plus the flag register.
    logic [ENT_W-1:0] mq[$];
    logic [3:0]       m_status;

    function automatic logic [ENT_W-1:0] in_ent();
        return {alu_result, wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, store_val_in};
    endfunction

    function automatic logic [3:0] flags_of(input logic [DATA_W-1:0] r, input logic c, input logic v);
        return {r[DATA_W-1], (r == 0) ? 1'b1 : 1'b0, c, v};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        logic acc;
        logic drn;
        if (!rst_n) begin
            mq.delete();
            m_status = 4'b0000;
        end else begin
            acc = in_valid && (mq.size() < 2) && !flush;
            drn = (mq.size() != 0) && out_ready;
            if (acc && s_bit) m_status = flags_of(alu_result, alu_cout, alu_ovf);
            if (flush) begin
                if (mq.size() != 0) $display("[TB] flush drops %0d entries", mq.size());
                mq.delete();
            end else begin
                if (drn) begin
                    $display("[TB] drain result=%0h", mq[0][ENT_W-1 -: DATA_W]);
                    void'(mq.pop_front());
                end
                if (acc) mq.push_back(in_ent());
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [ENT_W-1:0] act;
        act = {alu_result_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, store_val_out};
        check("out_valid", ENT_W'(out_valid), ENT_W'(mq.size() != 0));
        check("in_ready", ENT_W'(in_ready), ENT_W'(mq.size() < 2));
        check("status", ENT_W'(status), ENT_W'(m_status));
        if (mq.size() != 0) check("entry", act, mq[0]);
        if (!rst_n) check("reset_data", act, '0);
`ifdef STATUS_FWD_EN
        if (rst_n) begin
            if (in_valid && (mq.size() < 2) && !flush && s_bit)
                check("status_fwd", ENT_W'(status_fwd), ENT_W'(flags_of(alu_result, alu_cout, alu_ovf)));
            else
                check("status_fwd", ENT_W'(status_fwd), ENT_W'(m_status));
        end
`endif
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] r, input logic s);
        in_valid     = 1'b1;
        alu_result   = r;
        s_bit        = s;
        alu_cout     = 1'b0;
        alu_ovf      = 1'b0;
        wb_en_in     = r[0];
        mem_r_en_in  = r[1];
        mem_w_en_in  = r[2];
        dest_in      = r[REG_ADDR_W-1:0];
        store_val_in = ~r;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_result = '0; alu_cout = 1'b0; alu_ovf = 1'b0; s_bit = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        dest_in = '0; store_val_in = '0;
        repeat (2) cycle();
        @(negedge clk);
        check("rst_out_valid", ENT_W'(out_valid), '0);
        check("rst_status", ENT_W'(status), '0);
        check("rst_result", ENT_W'(alu_result_out), '0);
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", ENT_W'(in_ready), ENT_W'(1));

        // Single entry, then flag updates.
        cycle();
        out_ready = 1'b1;
        push(32'h0000_0005, 1'b1);
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid", ENT_W'(out_valid), ENT_W'(1));
        check("t1_result", ENT_W'(alu_result_out), ENT_W'(5));
        check("t1_status", ENT_W'(status), ENT_W'(4'b0000));
        cycle();
        push(32'h0, 1'b1);
        alu_cout = 1'b1;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_zc", ENT_W'(status), ENT_W'(4'b0110));
        cycle();
        push(32'h8000_0000, 1'b0);
        alu_ovf = 1'b1;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_hold", ENT_W'(status), ENT_W'(4'b0110));
        cycle();
        push(32'h0, 1'b1);
        @(negedge clk);
`ifdef STATUS_FWD_EN
        check("fwd_same_cycle", ENT_W'(status_fwd), ENT_W'(4'b0100));
`endif
        check("fwd_pre_status", ENT_W'(status), ENT_W'(4'b0110));
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("fwd_next_status", ENT_W'(status), ENT_W'(4'b0100));
        repeat (2) cycle();

        // Backpressure.
        out_ready = 1'b0;
        push(32'd1, 1'b0);
        cycle();
        push(32'd2, 1'b0);
        cycle();
        push(32'd3, 1'b0);
        @(negedge clk);
        check("bp_in_ready", ENT_W'(in_ready), ENT_W'(0));
        check("bp_head", ENT_W'(alu_result_out), ENT_W'(1));
        cycle();
        @(negedge clk);
        check("bp_hold_head", ENT_W'(alu_result_out), ENT_W'(1));
        check("bp_held_off", ENT_W'(in_ready), ENT_W'(0));
        cycle();
        out_ready = 1'b1;
        cycle();
        @(negedge clk);
        check("bp_second", ENT_W'(alu_result_out), ENT_W'(2));
        check("bp_ready_back", ENT_W'(in_ready), ENT_W'(1));
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_third", ENT_W'(alu_result_out), ENT_W'(3));
        check("bp_third_valid", ENT_W'(out_valid), ENT_W'(1));
        cycle();
        @(negedge clk);
        check("bp_empty", ENT_W'(out_valid), ENT_W'(0));

        // Flush with both registers full.
        cycle();
        out_ready = 1'b0;
        push(32'd10, 1'b0);
        cycle();
        push(32'd11, 1'b0);
        cycle();
        push(32'd7, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_valid", ENT_W'(out_valid), ENT_W'(0));
        check("fl_ready", ENT_W'(in_ready), ENT_W'(1));
        check("fl_status", ENT_W'(status), ENT_W'(4'b0100));
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            check("fl_no7", ENT_W'(out_valid), ENT_W'(0));
        end

        // Full throughput.
        cycle();
        for (int i = 0; i < 8; i++) begin
            push(DATA_W'(i), 1'b0);
            cycle();
            @(negedge clk);
            check("tp_valid", ENT_W'(out_valid), ENT_W'(1));
            check("tp_value", ENT_W'(alu_result_out), ENT_W'(i));
            check("tp_no_skid", ENT_W'(in_ready), ENT_W'(1));
        end
        cycle();
        in_valid = 1'b0;

        // Reset asserted mid-transfer.
        out_ready = 1'b0;
        push(32'h55, 1'b1);
        cycle();
        push(32'h66, 1'b0);
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", ENT_W'(out_valid), ENT_W'(0));
        check("mr_ready", ENT_W'(in_ready), ENT_W'(1));
        check("mr_status", ENT_W'(status), ENT_W'(0));
        check("mr_result", ENT_W'(alu_result_out), ENT_W'(0));
        cycle();
        rst_n = 1'b1;

        // Mixed traffic against the model.
        for (int i = 0; i < 60; i++) begin
            push(DATA_W'($urandom), 1'($urandom));
            in_valid  = 1'($urandom);
            alu_cout  = 1'($urandom);
            alu_ovf   = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
